// File: rtl/nvdla_mcif_rd_wrr_arb.sv
// Weighted round-robin arbiter for the MCIF read-request path.
// Credit-based WRR with outstanding-request throttling and a single registered egress stage.
module nvdla_mcif_rd_wrr_arb #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned PAYLOAD_W   = 79,
  parameter int unsigned ID_W        = 2
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  input  logic [NUM_CLIENTS-1:0]         client_req_valid,
  output logic [NUM_CLIENTS-1:0]         client_req_ready,
  input  logic [NUM_CLIENTS*PAYLOAD_W-1:0] client_req_pd,
  input  logic [NUM_CLIENTS*8-1:0]       cfg_rd_weight,
  input  logic [7:0]                     cfg_rd_os_cnt,
  output logic                           arb_req_valid,
  input  logic                           arb_req_ready,
  output logic [PAYLOAD_W-1:0]           arb_req_pd,
  output logic [ID_W-1:0]                arb_req_id,
  input  logic                           rsp_done,
  output logic [7:0]                     outstanding_cnt,
  output logic                           idle,
  output logic                           err_underflow
);

  localparam int unsigned NSLOT = 1 << ID_W;

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_pd;
  logic [ID_W-1:0]      r_id;
  logic [ID_W-1:0]      r_last;
  logic [7:0]           r_os;
  logic                 r_err;
  logic                 r_idle;
  logic [7:0]           r_credit [NUM_CLIENTS];

  logic [7:0]           w_weight [NUM_CLIENTS];
  logic [NSLOT-1:0]     w_elig;
  logic                 w_has_req;
  logic                 w_found;
  logic [ID_W-1:0]      w_gidx;
  logic [ID_W-1:0]      w_gnext;
  logic [ID_W-1:0]      w_idx;
  logic [7:0]           w_gcredit;
  logic [PAYLOAD_W-1:0] w_gpd;
  logic                 w_slot_free;
  logic                 w_os_ok;
  logic [8:0]           w_os_sum;
  logic                 w_grant;
  logic                 w_refill;
  logic                 w_hs;

  // Per-client eligibility and refill demand
  always_comb begin
    w_elig    = '0;
    w_has_req = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      w_weight[i] = cfg_rd_weight[i*8 +: 8];
      w_elig[i]   = client_req_valid[i] && (r_credit[i] != 8'd0) && (w_weight[i] != 8'd0);
      if (client_req_valid[i] && (w_weight[i] != 8'd0)) w_has_req = 1'b1;
    end
  end

  // First eligible client searching upward from last_grant, with wrap
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      w_idx = ID_W'((32'(r_last) + k) % NUM_CLIENTS);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    w_gnext = ID_W'((32'(w_gidx) + 32'd1) % NUM_CLIENTS);
  end

  always_comb begin
    w_gcredit = '0;
    w_gpd     = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (w_gidx == ID_W'(i)) begin
        w_gcredit = r_credit[i];
        w_gpd     = client_req_pd[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign w_slot_free = !r_valid || arb_req_ready;
  assign w_os_sum    = {1'b0, r_os} + 9'(r_valid);
  assign w_os_ok     = w_os_sum < {1'b0, cfg_rd_os_cnt};
  assign w_grant     = w_found && w_slot_free && w_os_ok;
  assign w_refill    = !w_found && w_has_req;
  assign w_hs        = r_valid && arb_req_ready;

  // Accept is combinational so the request is captured on the same edge
  always_comb begin
    client_req_ready = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      client_req_ready[i] = !nvdla_core_rst && w_grant && (w_gidx == ID_W'(i));
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_valid <= 1'b0;
      r_pd    <= '0;
      r_id    <= '0;
      r_last  <= '0;
      r_os    <= '0;
      r_err   <= 1'b0;
      r_idle  <= 1'b1;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) r_credit[i] <= '0;
    end else begin
      r_idle <= !r_valid && (r_os == 8'd0) && (client_req_valid == '0);
      if (w_grant) begin
        r_valid <= 1'b1;
        r_pd    <= w_gpd;
        r_id    <= w_gidx;
        r_last  <= (w_gcredit == 8'd1) ? w_gnext : w_gidx;
      end else if (arb_req_ready) begin
        r_valid <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        if (w_refill) r_credit[i] <= w_weight[i];
        else if (w_grant && (w_gidx == ID_W'(i))) r_credit[i] <= r_credit[i] - 8'd1;
      end
      // Coincident issue and completion cancel out
      if (w_hs && !rsp_done) begin
        if (r_os != 8'hFF) r_os <= r_os + 8'd1;
      end else if (!w_hs && rsp_done) begin
        if (r_os == 8'd0) r_err <= 1'b1;
        else r_os <= r_os - 8'd1;
      end
    end
  end

  assign arb_req_valid   = r_valid;
  assign arb_req_pd      = r_pd;
  assign arb_req_id      = r_id;
  assign outstanding_cnt = r_os;
  assign idle            = r_idle;
  assign err_underflow   = r_err;

endmodule
